// File: rtl/ahb_master_req_ctrl.sv
// Master-side AHB request controller: takes one local command, requests the bus and drives the address phase beat by beat.
// Latency: hreq rises the cycle after acceptance; done/timeout pulse the cycle after the last beat or the abort; stalls on hgrant=0.
module ahb_master_req_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic              cmd_write,
  output logic              hreq,
  input  logic              hgrant,
  output logic [1:0]        htrans,
  output logic [ADDR_W-1:0] haddr,
  output logic [2:0]        hburst,
  output logic              hwrite,
  output logic              beat_ack,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  // Abort on the last of 2**TIMEOUT_W-1 consecutive ungranted cycles.
  localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = WAIT_MAX - 1'b1;

  state_t               state;
  logic [ADDR_W-1:0]    start_addr;
  logic [2:0]           lat_burst;
  logic                 lat_write;
  logic [3:0]           beats_left;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[1:0];

  assign cmd_ready = (state == S_IDLE);
  assign beat_ack  = (state == S_XFER) && hgrant;

  // Wrapping bursts only advance the bits inside the wrap window; INCR uses the full mask.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0]        b);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    inc = a + ADDR_W'(4);
    case (b)
      3'd2:    mask = ADDR_W'(32'h0000_000C);
      3'd4:    mask = ADDR_W'(32'h0000_001C);
      3'd6:    mask = ADDR_W'(32'h0000_003C);
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  function automatic logic [3:0] last_beat(input logic [2:0] b);
    case (b[2:1])
      2'd0:    return 4'd0;
      2'd1:    return 4'd3;
      2'd2:    return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state      <= S_IDLE;
      hreq       <= 1'b0;
      htrans     <= TR_IDLE;
      haddr      <= '0;
      hburst     <= 3'd0;
      hwrite     <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      start_addr <= '0;
      lat_burst  <= 3'd0;
      lat_write  <= 1'b0;
      beats_left <= 4'd0;
      wait_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            start_addr <= {cmd_addr[ADDR_W-1:2], 2'b00};
            lat_burst  <= cmd_burst;
            lat_write  <= cmd_write;
            beats_left <= last_beat(cmd_burst);
            wait_cnt   <= '0;
            hreq       <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (hgrant) begin
            htrans <= TR_NONSEQ;
            haddr  <= start_addr;
            hburst <= lat_burst;
            hwrite <= lat_write;
            state  <= S_XFER;
          end else if (wait_cnt == WAIT_LAST) begin
            hreq    <= 1'b0;
            timeout <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (hgrant) begin
            if (beats_left != 4'd0) begin
              haddr      <= next_addr(haddr, hburst);
              htrans     <= TR_SEQ;
              beats_left <= beats_left - 4'd1;
            end else begin
              hreq   <= 1'b0;
              htrans <= TR_IDLE;
              done   <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Randomized bench for ahb_master_req_ctrl: per-command reference model derives each beat's address from the burst rules.
module tb_ahb_master_req_ctrl;

  localparam int TW         = 4;
  localparam int WAIT_LIMIT = (1 << TW) - 1;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic        cmd_write;
  logic        hreq;
  logic        hgrant;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic        hwrite;
  logic        beat_ack;
  logic        done;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  ahb_master_req_ctrl #(.ADDR_W(32), .TIMEOUT_W(TW)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_burst(cmd_burst), .cmd_write(cmd_write),
    .hreq(hreq), .hgrant(hgrant), .htrans(htrans), .haddr(haddr),
    .hburst(hburst), .hwrite(hwrite), .beat_ack(beat_ack),
    .done(done), .timeout(timeout)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nbeats(input logic [2:0] b);
    case (b)
      3'd0, 3'd1: return 1;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  // Beat i of a burst: INCR walks linearly, WRAP stays inside a window of nbeats*4 bytes.
  function automatic logic [31:0] exp_addr(input logic [31:0] st, input logic [2:0] b, input int i);
    logic [31:0] win;
    logic [31:0] lin;
    lin = st + 32'(4 * i);
    if (b == 3'd0 || b[0]) return lin;
    win = 32'(4 * nbeats(b) - 1);
    return (st & ~win) | (lin & win);
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic run_cmd(input logic [31:0] addr, input logic [2:0] b, input logic w,
                         input int pct, input int stall_beat, input int rst_beat);
    logic [31:0] st;
    int n, beat, waits, stalls, cyc;
    bit granted, g, fin, tmo;
    st = {addr[31:2], 2'b00};
    n = nbeats(b);
    beat = 0; waits = 0; stalls = 0; cyc = 0;
    granted = 0; fin = 0; tmo = 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_addr = addr; cmd_burst = b; cmd_write = w; hgrant = 0;
    tick();
    cmd_valid = 0;
    while (!fin) begin
      chk("hreq_busy", hreq, 1);
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("done_busy", done, 0);
      chk("timeout_busy", timeout, 0);
      if (!granted) begin
        chk("htrans_req", htrans, 2'b00);
      end else begin
        chk("htrans_xfer", htrans, (beat == 0) ? 2'b10 : 2'b11);
        chk("haddr", haddr, exp_addr(st, b, beat));
        chk("hburst", hburst, b);
        chk("hwrite", hwrite, w);
      end
      if (granted && beat == rst_beat) begin
        hgrant = 1; cmd_valid = 0;
        hreset_n = 0;
        #1;
        chk("rst_hreq", hreq, 0);
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_haddr", haddr, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_beat_ack", beat_ack, 0);
        tick();
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_hreq_hold", hreq, 0);
        hgrant = 0;
        hreset_n = 1;
        tick();
        return;
      end
      g = ($urandom_range(0, 99) < pct);
      if (granted && beat == stall_beat && stalls < 2) begin
        g = 0;
        stalls++;
      end
      hgrant = g;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_burst = 3'($urandom_range(0, 7));
      cmd_write = 1'($urandom_range(0, 1));
      #1;
      chk("beat_ack", beat_ack, granted && g);
      if (!granted) begin
        if (g) granted = 1;
        else begin
          waits++;
          if (waits == WAIT_LIMIT) begin fin = 1; tmo = 1; end
        end
      end else if (g) begin
        beat++;
        if (beat == n) fin = 1;
      end
      cyc++;
      if (cyc > 2000) begin
        chk("cycle_budget", 0, 1);
        fin = 1;
      end
      tick();
      if (fin) cmd_valid = 0;
    end
    hgrant = 0;
    cmd_valid = 0;
    chk("done_pulse", done, tmo ? 0 : 1);
    chk("timeout_pulse", timeout, tmo ? 1 : 0);
    chk("hreq_end", hreq, 0);
    chk("htrans_end", htrans, 2'b00);
    chk("cmd_ready_end", cmd_ready, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("timeout_one_cycle", timeout, 0);
    chk("hreq_stays_low", hreq, 0);
  endtask

  initial begin
    hreset_n = 0; cmd_valid = 0; cmd_addr = 0; cmd_burst = 0; cmd_write = 0; hgrant = 0;
    repeat (2) tick();
    chk("reset_hreq", hreq, 0);
    chk("reset_htrans", htrans, 2'b00);
    chk("reset_haddr", haddr, 0);
    chk("reset_hburst", hburst, 0);
    chk("reset_hwrite", hwrite, 0);
    chk("reset_done", done, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    hreset_n = 1;
    tick();
    chk("post_reset_hreq", hreq, 0);
    chk("post_reset_cmd_ready", cmd_ready, 1);

    run_cmd(32'h0000_0100, 3'd0, 1'b1, 100, -1, -1);
    run_cmd(32'h0000_0200, 3'd3, 1'b0, 100, -1, -1);
    run_cmd(32'h0000_03F8, 3'd4, 1'b1, 100, -1, -1);
    run_cmd(32'h0000_0200, 3'd3, 1'b1, 100, 1, -1);
    run_cmd(32'h0000_0400, 3'd5, 1'b0, 0, -1, -1);
    run_cmd(32'h0000_0800, 3'd7, 1'b1, 100, -1, 5);
    run_cmd(32'h0000_010E, 3'd2, 1'b0, 100, -1, -1);

    for (int k = 0; k < 40; k++) begin
      run_cmd($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              $urandom_range(30, 100), -1, -1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
